// File: rtl/dark_pkg.sv
// dark_pkg: shared definitions for the dark_decode slice.
//   - RV32I major-opcode constants
//   - inst_cls_e : 4-bit instruction class reported to execute
//   - imm_fmt_e  : immediate format selector for imm_gen()
//   - decoded_t  : one decoded instruction as held in the output slots
//   - imm_gen()  : sign-extending immediate builder for all RV32I formats
package dark_pkg;

    localparam int unsigned DARK_XLEN = 32;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BCC   = 7'b1100011;
    localparam logic [6:0] OP_LCC   = 7'b0000011;
    localparam logic [6:0] OP_SCC   = 7'b0100011;
    localparam logic [6:0] OP_MCC   = 7'b0010011;
    localparam logic [6:0] OP_RCC   = 7'b0110011;
    localparam logic [6:0] OP_FCC   = 7'b0001111;
    localparam logic [6:0] OP_CCC   = 7'b1110011;
    localparam logic [6:0] OP_MAC   = 7'b1111111;

    typedef enum logic [3:0] {
        CLS_NOP   = 4'd0,
        CLS_LUI   = 4'd1,
        CLS_AUIPC = 4'd2,
        CLS_JAL   = 4'd3,
        CLS_JALR  = 4'd4,
        CLS_BCC   = 4'd5,
        CLS_LCC   = 4'd6,
        CLS_SCC   = 4'd7,
        CLS_MCC   = 4'd8,
        CLS_RCC   = 4'd9,
        CLS_MAC   = 4'd10
    } inst_cls_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [DARK_XLEN-1:0] pc;
        inst_cls_e            cls;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [2:0]           fct3;
        logic [6:0]           fct7;
        logic [DARK_XLEN-1:0] imm;
        logic                 illegal;
    } decoded_t;

    // Takes inst[31:7] only: the opcode bits never contribute to an immediate.
    function automatic logic [31:0] imm_gen(input logic [31:7] ib, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{ib[31]}}, ib[31:20]};
            IMM_S:   imm = {{20{ib[31]}}, ib[31:25], ib[11:7]};
            IMM_B:   imm = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
            IMM_U:   imm = {ib[31:12], 12'd0};
            IMM_J:   imm = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/dark_skid.sv
// dark_skid: two-entry valid/ready elastic buffer for decoded_t with flush.
//   clk, res           : clock, asynchronous active-high reset
//   flush              : empties both entries, discards a same-cycle input
//   in_valid/in_ready  : upstream handshake (in_ready is a pure flop output)
//   in_data            : entry to load
//   out_valid/out_ready: downstream handshake
//   out_data           : main-slot contents, held stable while stalled
// The main slot drives the outputs; the skid slot catches the one extra
// entry that arrives in the cycle execute first stalls.
module dark_skid
    import dark_pkg::*;
#(
    parameter decoded_t RST_VAL = '0
) (
    input  logic     clk,
    input  logic     res,
    input  logic     flush,
    input  logic     in_valid,
    output logic     in_ready,
    input  decoded_t in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output decoded_t out_data
);

    decoded_t main_q, main_d;
    decoded_t skid_q, skid_d;
    logic     main_vld_q, main_vld_d;
    logic     skid_vld_q, skid_vld_d;
    logic     rdy_q, rdy_d;
    logic     accept_s;
    logic     drain_s;

    assign accept_s = in_valid & rdy_q;
    assign drain_s  = main_vld_q & out_ready;

    // Next-state for both slots; flush overrides every transfer.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || drain_s) begin
            // Main slot is free this cycle: refill from skid first to keep order.
            // rdy_q is low whenever the skid is full, so no input arrives then.
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept_s) begin
                main_d     = in_data;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_d     = in_data;
                skid_vld_d = 1'b1;
            end else begin
                skid_vld_d = skid_vld_q;
            end
        end
        // Ready is registered from the next skid state so it never sees out_ready combinationally.
        rdy_d = ~skid_vld_d;
    end

    // Slot and ready registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            main_q     <= RST_VAL;
            skid_q     <= RST_VAL;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = main_vld_q;
    assign out_data  = main_q;

endmodule

// File: rtl/dark_decode.sv
// dark_decode: RV32I decode stage between fetch and execute.
//   clk, res               : clock, asynchronous active-high reset
//   in_valid/in_ready      : fetch handshake; in_pc/in_inst the presented word
//   flush                  : drop everything held plus any same-cycle input
//   out_valid/out_ready    : execute handshake
//   out_pc, out_cls, out_rd, out_rs1, out_rs2, out_fct3, out_fct7,
//   out_imm, out_illegal   : registered decoded fields
// Optional feature macro DARK_DECODE_MAC_EN: when defined, opcode 7'b1111111
// decodes as CLS_MAC (R-type, imm 0, rd written); otherwise it is illegal.
module dark_decode
    import dark_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            res,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_inst,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_cls,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_fct3,
    output logic [6:0]      out_fct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    localparam decoded_t RST_DEC = '{
        pc:      DARK_XLEN'(RESET_PC),
        cls:     CLS_NOP,
        rd:      5'd0,
        rs1:     5'd0,
        rs2:     5'd0,
        fct3:    3'd0,
        fct7:    7'd0,
        imm:     32'd0,
        illegal: 1'b0
    };

    logic [31:0] inst_s;
    logic [6:0]  opcode_s;
    imm_fmt_e    fmt_s;
    decoded_t    dec_s;
    decoded_t    held_s;

    assign inst_s   = DARK_XLEN'(in_inst);
    assign opcode_s = inst_s[6:0];

    // Combinational decode of the presented instruction word.
    always_comb begin
        dec_s.pc      = DARK_XLEN'(in_pc);
        dec_s.cls     = CLS_NOP;
        dec_s.rd      = inst_s[11:7];
        dec_s.rs1     = inst_s[19:15];
        dec_s.rs2     = inst_s[24:20];
        dec_s.fct3    = inst_s[14:12];
        dec_s.fct7    = inst_s[31:25];
        dec_s.illegal = 1'b0;
        fmt_s         = IMM_NONE;
        if (inst_s[1:0] != 2'b11) begin
            dec_s.illegal = 1'b1;
        end else begin
            case (opcode_s)
                OP_LUI:   begin dec_s.cls = CLS_LUI;   fmt_s = IMM_U; end
                OP_AUIPC: begin dec_s.cls = CLS_AUIPC; fmt_s = IMM_U; end
                OP_JAL:   begin dec_s.cls = CLS_JAL;   fmt_s = IMM_J; end
                OP_JALR:  begin dec_s.cls = CLS_JALR;  fmt_s = IMM_I; end
                OP_BCC:   begin dec_s.cls = CLS_BCC;   fmt_s = IMM_B; end
                OP_LCC:   begin dec_s.cls = CLS_LCC;   fmt_s = IMM_I; end
                OP_SCC:   begin dec_s.cls = CLS_SCC;   fmt_s = IMM_S; end
                OP_MCC:   begin dec_s.cls = CLS_MCC;   fmt_s = IMM_I; end
                OP_RCC:   begin dec_s.cls = CLS_RCC;   fmt_s = IMM_NONE; end
                // Fence and system instructions are legal but do nothing here.
                OP_FCC:   begin dec_s.cls = CLS_NOP;   fmt_s = IMM_NONE; end
                OP_CCC:   begin dec_s.cls = CLS_NOP;   fmt_s = IMM_NONE; end
`ifdef DARK_DECODE_MAC_EN
                OP_MAC:   begin dec_s.cls = CLS_MAC;   fmt_s = IMM_NONE; end
`endif
                default:  begin dec_s.illegal = 1'b1;  fmt_s = IMM_NONE; end
            endcase
        end
        dec_s.imm = imm_gen(inst_s[31:7], fmt_s);
        // Classes without a destination report rd=0; illegal words land on CLS_NOP.
        if ((dec_s.cls == CLS_BCC) || (dec_s.cls == CLS_SCC) || (dec_s.cls == CLS_NOP)) begin
            dec_s.rd = 5'd0;
        end else begin
            dec_s.rd = inst_s[11:7];
        end
    end

    dark_skid #(
        .RST_VAL (RST_DEC)
    ) u_skid (
        .clk       (clk),
        .res       (res),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (held_s)
    );

    assign out_pc      = XLEN'(held_s.pc);
    assign out_cls     = held_s.cls;
    assign out_rd      = held_s.rd;
    assign out_rs1     = held_s.rs1;
    assign out_rs2     = held_s.rs2;
    assign out_fct3    = held_s.fct3;
    assign out_fct7    = held_s.fct7;
    assign out_imm     = XLEN'(held_s.imm);
    assign out_illegal = held_s.illegal;

endmodule

// File: tb/tb_dark_decode.sv
// Directed self-checking bench for dark_decode.
module tb_dark_decode;
    import dark_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_1000;

`ifdef DARK_DECODE_MAC_EN
    localparam logic [31:0] MAC_CLS = 32'd10;
    localparam logic [31:0] MAC_ILL = 32'd0;
`else
    localparam logic [31:0] MAC_CLS = 32'd0;
    localparam logic [31:0] MAC_ILL = 32'd1;
`endif

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = 32'd0;
    logic [31:0] in_inst = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [3:0]  out_cls;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_fct3;
    logic [6:0]  out_fct7;
    logic [31:0] out_imm;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;

    dark_decode #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk(clk), .res(res),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_cls(out_cls), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_fct3(out_fct3), .out_fct7(out_fct7), .out_imm(out_imm),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    // Checks a flowing output slot: valid plus pc.
    task automatic chk_out(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
    endtask

    initial begin
        // ---- reset ----
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_pc", out_pc, RPC);
        chk("rst_cls", {28'd0, out_cls}, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        step();
        res = 1'b0;
        step();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_pc", out_pc, RPC);

        // ---- flowing decode, out_ready=1 ----
        drive(1'b1, 32'h100, 32'h0050_0093);          // addi x1,x0,5
        step();
        chk_out("addi", 32'h100);
        chk("addi_cls", {28'd0, out_cls}, 32'd8);
        chk("addi_rd", {27'd0, out_rd}, 32'd1);
        chk("addi_rs1", {27'd0, out_rs1}, 32'd0);
        chk("addi_imm", out_imm, 32'd5);
        chk("addi_ill", {31'd0, out_illegal}, 32'd0);
        drive(1'b1, 32'h104, 32'hFE20_8EE3);          // beq x1,x2,-4
        step();
        chk_out("beq", 32'h104);
        chk("beq_cls", {28'd0, out_cls}, 32'd5);
        chk("beq_rd", {27'd0, out_rd}, 32'd0);
        chk("beq_rs1", {27'd0, out_rs1}, 32'd1);
        chk("beq_rs2", {27'd0, out_rs2}, 32'd2);
        chk("beq_fct7", {25'd0, out_fct7}, 32'h7F);
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        drive(1'b1, 32'h108, 32'h1234_52B7);          // lui x5,0x12345
        step();
        chk_out("lui", 32'h108);
        chk("lui_cls", {28'd0, out_cls}, 32'd1);
        chk("lui_rd", {27'd0, out_rd}, 32'd5);
        chk("lui_imm", out_imm, 32'h1234_5000);
        drive(1'b1, 32'h10C, 32'h0020_A423);          // sw x2,8(x1)
        step();
        chk("sw_cls", {28'd0, out_cls}, 32'd7);
        chk("sw_rd", {27'd0, out_rd}, 32'd0);
        chk("sw_imm", out_imm, 32'd8);
        drive(1'b1, 32'h110, 32'hFFC0_80E7);          // jalr x1,-4(x1)
        step();
        chk("jalr_cls", {28'd0, out_cls}, 32'd4);
        chk("jalr_rd", {27'd0, out_rd}, 32'd1);
        chk("jalr_imm", out_imm, 32'hFFFF_FFFC);
        drive(1'b1, 32'h114, 32'h0080_00EF);          // jal x1,+8
        step();
        chk("jal_cls", {28'd0, out_cls}, 32'd3);
        chk("jal_rd", {27'd0, out_rd}, 32'd1);
        chk("jal_imm", out_imm, 32'd8);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // ---- backpressure ----
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'h0000_0013);
        step();
        chk_out("bp0", 32'h0);
        chk("bp0_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'h4, 32'h0000_0013);
        step();
        chk_out("bp1", 32'h0);
        chk("bp1_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'h8, 32'h0000_0013);
        step();
        chk_out("bp2", 32'h0);
        chk("bp2_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk_out("bp3", 32'h0);
        out_ready = 1'b1;
        step();
        chk_out("rel_a", 32'h4);
        chk("rel_a_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk_out("rel_b", 32'h8);
        drive(1'b1, 32'hC, 32'h0000_0013);
        step();
        chk_out("rel_c", 32'hC);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("rel_end_valid", {31'd0, out_valid}, 32'd0);

        // ---- flush with both slots full ----
        out_ready = 1'b0;
        drive(1'b1, 32'h200, 32'h0000_0013);
        step();
        drive(1'b1, 32'h204, 32'h0000_0013);
        step();
        chk("fl_full_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'h208, 32'h0000_0013);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        step();
        chk("fl_after_valid", {31'd0, out_valid}, 32'd0);

        // ---- flush discards a same-cycle accepted input ----
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 32'h0000_0013);
        step();
        drive(1'b1, 32'h304, 32'h0000_0013);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl2_valid", {31'd0, out_valid}, 32'd0);
        chk("fl2_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("fl2_after_valid", {31'd0, out_valid}, 32'd0);

        // ---- illegal and MAC ----
        drive(1'b1, 32'h400, 32'h0000_0010);          // addi with inst[1:0]=00
        step();
        chk_out("ill_lo", 32'h400);
        chk("ill_lo_flag", {31'd0, out_illegal}, 32'd1);
        chk("ill_lo_cls", {28'd0, out_cls}, 32'd0);
        drive(1'b1, 32'h404, 32'h0000_058B);          // unlisted opcode 0001011, rd=11
        step();
        chk_out("ill_op", 32'h404);
        chk("ill_op_flag", {31'd0, out_illegal}, 32'd1);
        chk("ill_op_rd", {27'd0, out_rd}, 32'd0);
        drive(1'b1, 32'h408, 32'h0000_007F);
        step();
        chk_out("mac", 32'h408);
        chk("mac_cls", {28'd0, out_cls}, MAC_CLS);
        chk("mac_ill", {31'd0, out_illegal}, MAC_ILL);
        drive(1'b1, 32'h40C, 32'h0000_000F);          // fence
        step();
        chk("fence_cls", {28'd0, out_cls}, 32'd0);
        chk("fence_ill", {31'd0, out_illegal}, 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        step();

        // ---- async reset mid-stall ----
        out_ready = 1'b0;
        drive(1'b1, 32'h500, 32'h0000_0013);
        step();
        drive(1'b1, 32'h504, 32'h0000_0013);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk_out("pre_ares", 32'h500);
        #2 res = 1'b1;
        #1;
        chk("ares_valid", {31'd0, out_valid}, 32'd0);
        chk("ares_ready", {31'd0, in_ready}, 32'd1);
        chk("ares_pc", out_pc, RPC);
        #1 res = 1'b0;
        out_ready = 1'b1;
        step();
        chk("ares_after1", {31'd0, out_valid}, 32'd0);
        step();
        chk("ares_after2", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dark_decode.md
Name: dark_decode

Overview:
- Decode stage directly downstream of the instruction fetch stage.
- Accepts one fetched {pc, inst} per valid/ready handshake and decodes it into instruction class, register indices, funct fields and a sign-extended immediate.
- Registers the result, with a one-entry skid slot so that backpressure from execute never drops or duplicates an instruction.
- Supports a pipeline flush for taken branches and jumps.

Parameters:
- XLEN, 32, datapath width of pc, inst and imm.
- RESET_PC, 32'h0, value of out_pc under reset.

Ports:
- clk  in  1  clock, all state updates on rising edge
- res  in  1  reset, asynchronous, active-high
- in_valid  in  1  fetch presents a valid instruction
- in_ready  out  1  decode can accept this cycle
- in_pc  in  XLEN  pc of presented instruction
- in_inst  in  XLEN  presented instruction word
- flush  in  1  discard all held and incoming instructions
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute consumes this cycle
- out_pc  out  XLEN  pc of decoded instruction
- out_cls  out  4  instruction class (package enum)
- out_rd  out  5  destination register, 0 when the class writes no rd
- out_rs1  out  5  inst[19:15]
- out_rs2  out  5  inst[24:20]
- out_fct3  out  3  inst[14:12]
- out_fct7  out  7  inst[31:25]
- out_imm  out  XLEN  sign-extended immediate for the class
- out_illegal  out  1  unrecognised encoding

Behaviour:
- Reset (async, res=1):
  - out_valid=0, skid empty, in_ready=1.
  - out_pc=RESET_PC; all other data outputs 0; out_cls=CLS_NOP.
  - Reset mid-transfer drops everything held.
- Transfer rules:
  - Input transfer on in_valid&&in_ready.
  - Output transfer on out_valid&&out_ready.
  - in_ready = !skid_valid, driven directly from a flop; no combinational path from out_ready.
- Latency: instruction accepted in cycle N appears on outputs in cycle N+1 when the main slot is free or draining.
- Slot logic:
  - Main slot empty or draining: accepted input loads the main slot.
  - Main slot full and stalled: accepted input loads the skid slot.
  - When the main slot drains and the skid is full, the skid moves to main and the skid empties.
- Output stability: outputs hold stable while out_valid&&!out_ready.
- Ordering: strict FIFO order; maximum 2 instructions held.
- Flush:
  - Synchronous; next cycle out_valid=0 and skid empty.
  - An input transferring in the same cycle as flush is discarded.
  - flush has priority over all transfers.
- Decode is combinational on in_inst, registered into the slot. Classes:
  - LUI=0110111, AUIPC=0010111, JAL=1101111, JALR=1100111
  - BCC=1100011, LCC=0000011, SCC=0100011, MCC=0010011, RCC=0110011
  - FCC=0001111 and CCC=1110011 both decode as CLS_NOP, legal.
- Immediates (RV32I):
  - I: LCC, MCC, JALR
  - S: SCC
  - B: BCC, bit0=0
  - U: LUI, AUIPC, low 12 bits=0
  - J: JAL, bit0=0
  - RCC, NOP: imm=0
- out_rd forced to 0 for BCC, SCC and NOP classes.
- Illegal: inst[1:0]!=2'b11 or unlisted opcode gives out_illegal=1, out_cls=CLS_NOP, out_rd=0. The instruction is still passed in order, not dropped.

Optional Feature:
- Macro: DARK_DECODE_MAC_EN.
- Defined: opcode 1111111 decodes as CLS_MAC, R-type fields, imm=0, rd live, legal.
- Undefined: opcode 1111111 is illegal; CLS_MAC encoding is unused.

Decomposition:
- Package dark_pkg holds:
  - opcode localparams
  - inst_cls_e enum (CLS_NOP, LUI, AUIPC, JAL, JALR, BCC, LCC, SCC, MCC, RCC, MAC)
  - decoded_t struct {pc, cls, rd, rs1, rs2, fct3, fct7, imm, illegal}
- Sub-module dark_skid: generic 2-entry valid/ready elastic buffer carrying decoded_t, with flush.
- dark_decode = combinational decoder + dark_skid.

Test Plan:
- After reset release: out_valid=0, in_ready=1, out_pc=RESET_PC.
- Decode, out_ready=1, each one cycle after acceptance:
  - in_inst=0x00500093 (addi x1,x0,5), in_pc=0x100 -> next cycle out_valid=1, cls=MCC, rd=1, rs1=0, imm=5, out_pc=0x100.
  - 0xFE208EE3 (beq x1,x2,-4) -> cls=BCC, rd=0, rs1=1, rs2=2, imm=0xFFFFFFFC.
  - 0x123452B7 (lui x5) -> cls=LUI, rd=5, imm=0x12345000.
- Backpressure: stream pc 0x0,0x4,0x8,0xC with out_ready=0 for 4 cycles -> in_ready=0 after 2 accepts; outputs stable at pc 0x0. Release -> 0x0,0x4,0x8,0xC emerge in order, no gaps once flowing, no duplicates.
- Flush with both slots full and in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed pcs never appear.
- Illegal and MAC:
  - 0x00000013 with inst[1:0] forced to 00 -> out_illegal=1, cls=CLS_NOP.
  - 0x0000007F -> illegal without DARK_DECODE_MAC_EN; cls=MAC, illegal=0 with it.
- Assert res asynchronously mid-stall -> out_valid drops before the next clock edge; nothing emerges after release.
